// File: rtl/wb_arbiter_pkg.sv
// Shared CPU definitions for the writeback path: datapath width, register address width
// and the queued writeback entry {rd, wd}.
package wb_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback FIFO: two ordered pushes (port 0 is older) and one pop per cycle.
// Push lands at the edge it is requested. The caller must never push more than the free slots.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0_vld,
  input  wb_entry_t              push0_dat,
  input  logic                   push1_vld,
  input  wb_entry_t              push1_dat,
  input  logic                   pop,
  output wb_entry_t              head_dat,
  output logic [CW-1:0]          count,
  output wb_entry_t [DEPTH-1:0]  ents_dat,
  output logic [DEPTH-1:0]       ents_vld
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q + AW'(push0_vld) + AW'(push1_vld);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push0_vld) + CW'(push1_vld) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // A lone push1 takes the slot at wptr so entries stay contiguous.
  always_ff @(posedge clk) begin
    if (push0_vld)      mem_q[wptr_q] <= push0_dat;
    else if (push1_vld) mem_q[wptr_q] <= push1_dat;
    if (push0_vld && push1_vld) mem_q[wptr_q + AW'(1)] <= push1_dat;
  end

  // Entries are presented rotated so index 0 is the oldest.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ents_dat[k] = mem_q[rptr_q + AW'(k)];
      ents_vld[k] = (CW'(k) < count_q);
    end
  end

  assign head_dat = mem_q[rptr_q];
  assign count    = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: mem/ALU results into an in-order FIFO, one registered regfile write per cycle,
// plus a busy scoreboard. Optional in-flight forwarding is built when WB_FWD_EN is defined.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_wd,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_wd,
  output logic              alu_ready,
  input  logic              issue_mark,
  input  logic [4:0]        issue_rd,
  output logic [31:0]       busy,
  output logic [4:0]        rd,
  output logic [XLEN-1:0]   wd,
  output logic              reg_write,
  input  logic [4:0]        fwd_rs,
  output logic              fwd_hit,
  output logic [XLEN-1:0]   fwd_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] ents_dat;
  logic [DEPTH-1:0]      ents_vld;
  logic [CW-1:0]         count, free;
  logic                  mem_push, alu_push, pop;

  logic                  reg_write_q, reg_write_d;
  logic [4:0]            rd_q, rd_d;
  logic [XLEN-1:0]       wd_q, wd_d;
  logic [31:0]           busy_q, busy_d;

  // Readies use pre-pop occupancy only, so a full FIFO stalls even while draining.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = !rst && (free != '0);
  assign alu_ready = !rst && (mem_valid ? (free >= CW'(2)) : (free != '0));
  assign mem_push  = mem_valid && mem_ready;
  assign alu_push  = alu_valid && alu_ready;
  assign pop       = (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push0_vld (mem_push),
    .push0_dat ('{rd: mem_rd, wd: mem_wd}),
    .push1_vld (alu_push),
    .push1_dat ('{rd: alu_rd, wd: alu_wd}),
    .pop       (pop),
    .head_dat  (head),
    .count     (count),
    .ents_dat  (ents_dat),
    .ents_vld  (ents_vld)
  );

  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wd_d        = wd_q;
    busy_d      = busy_q;
    if (pop) begin
      reg_write_d       = (head.rd != '0);
      rd_d              = head.rd;
      wd_d              = head.wd;
      busy_d[head.rd]   = 1'b0;
    end
    // A new issue to the same register outranks the retiring write.
    if (issue_mark && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wd_q        <= '0;
      busy_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
      busy_q      <= busy_d;
    end
  end

  assign reg_write = reg_write_q;
  assign rd        = rd_q;
  assign wd        = wd_q;
  assign busy      = busy_q;

`ifdef WB_FWD_EN
  // Scan oldest to youngest (output register, then FIFO in age order); last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != '0) begin
      if (reg_write_q && rd_q == fwd_rs) begin
        fwd_hit  = 1'b1;
        fwd_data = wd_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (ents_vld[k] && ents_dat[k].rd == fwd_rs) begin
          fwd_hit  = 1'b1;
          fwd_data = ents_dat[k].wd;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, ents_dat, ents_vld};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid, mem_ready, alu_ready;
  logic [4:0]  mem_rd, alu_rd, issue_rd, rd, fwd_rs;
  logic [31:0] mem_wd, alu_wd, wd, busy, fwd_data;
  logic        issue_mark, reg_write, fwd_hit;

  int n_run  = 0;
  int n_fail = 0;

`ifdef WB_FWD_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .issue_mark(issue_mark), .issue_rd(issue_rd), .busy(busy),
    .rd(rd), .wd(wd), .reg_write(reg_write),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] t3_seq [8] = '{32'h100, 32'h200, 32'h101, 32'h201,
                              32'h102, 32'h103, 32'h104, 32'h105};
  logic        t3_ardy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int          t3_ret = 0;

  task automatic t3_capture();
    if (reg_write) begin
      if (t3_ret < 8) check($sformatf("t3_retire%0d", t3_ret), 64'(wd), 64'(t3_seq[t3_ret]));
      t3_ret++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mi, ai, wr_cnt;
    logic mf, af;
    rst = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0; issue_mark = 1'b0;
    mem_rd = '0; mem_wd = '0; alu_rd = '0; alu_wd = '0; issue_rd = '0; fwd_rs = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_reg_write", 64'(reg_write), 64'(0));
    check("rst_rd",        64'(rd),        64'(0));
    check("rst_wd",        64'(wd),        64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_mem_ready", 64'(mem_ready), 64'(0));
    check("rst_alu_ready", 64'(alu_ready), 64'(0));
    check("rst_fwd_hit",   64'(fwd_hit),   64'(0));
    check("rst_fwd_data",  64'(fwd_data),  64'(0));
    rst = 1'b0; #1;
    check("post_rst_mem_ready", 64'(mem_ready), 64'(1));
    check("post_rst_alu_ready", 64'(alu_ready), 64'(1));

    // Single mem result: visible the cycle after E+1
    mem_valid = 1'b1; mem_rd = 5'd5; mem_wd = 32'hDEADBEEF;
    @(negedge clk);
    mem_valid = 1'b0;
    check("t1_early_rw", 64'(reg_write), 64'(0));
    @(negedge clk);
    check("t1_rw", 64'(reg_write), 64'(1));
    check("t1_rd", 64'(rd),        64'(5));
    check("t1_wd", 64'(wd),        64'(32'hDEADBEEF));
    @(negedge clk);
    check("t1_rw_off",  64'(reg_write), 64'(0));
    check("t1_rd_hold", 64'(rd),        64'(5));

    // Same-cycle mem/ALU to the same register
    mem_valid = 1'b1; mem_rd = 5'd3; mem_wd = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h22;
    #1 check("t2_alu_ready", 64'(alu_ready), 64'(1));
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0; fwd_rs = 5'd3;
    #1;
    check("t2_fwd_hit_q2",  64'(fwd_hit),  64'(FE));
    check("t2_fwd_data_q2", 64'(fwd_data), FE ? 64'h22 : 64'h0);
    @(negedge clk);
    check("t2_first_rw", 64'(reg_write), 64'(1));
    check("t2_first_wd", 64'(wd),        64'(32'h11));
    check("t2_fwd_data_q1", 64'(fwd_data), FE ? 64'h22 : 64'h0);
    @(negedge clk);
    check("t2_second_rw", 64'(reg_write), 64'(1));
    check("t2_second_wd", 64'(wd),        64'(32'h22));
    check("t2_fwd_outreg", 64'(fwd_data), FE ? 64'h22 : 64'h0);
    @(negedge clk);
    check("t2_idle_rw",      64'(reg_write), 64'(0));
    check("t2_fwd_idle_hit", 64'(fwd_hit),   64'(0));
    fwd_rs = 5'd0;

    // Both producers held valid for 6 cycles
    mi = 0; ai = 0;
    for (int c = 0; c < 6; c++) begin
      mem_rd = 5'(1 + mi);  mem_wd = 32'(32'h100 + mi);
      alu_rd = 5'(10 + ai); alu_wd = 32'(32'h200 + ai);
      mem_valid = 1'b1; alu_valid = 1'b1;
      #1;
      check($sformatf("t3_mem_ready%0d", c), 64'(mem_ready), 64'(1));
      check($sformatf("t3_alu_ready%0d", c), 64'(alu_ready), 64'(t3_ardy[c]));
      mf = mem_ready; af = alu_ready;
      @(posedge clk);
      mi += int'(mf); ai += int'(af);
      @(negedge clk);
      t3_capture();
    end
    mem_valid = 1'b0;
    #1 check("t3_alu_ready_free1", 64'(alu_ready), 64'(1));
    alu_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      t3_capture();
    end
    check("t3_retire_count", 64'(t3_ret), 64'(8));

    // ALU write to x0 consumes a drain slot silently
    mem_valid = 1'b1; mem_rd = 5'd9; mem_wd = 32'h99;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFFFF;
    @(negedge clk);
    alu_valid = 1'b0; mem_rd = 5'd12; mem_wd = 32'hCC;
    check("t4_pre_rw", 64'(reg_write), 64'(0));
    @(negedge clk);
    mem_valid = 1'b0;
    check("t4_first_rw", 64'(reg_write), 64'(1));
    check("t4_first_wd", 64'(wd),        64'(32'h99));
    @(negedge clk);
    check("t4_x0_rw", 64'(reg_write), 64'(0));
    check("t4_x0_rd", 64'(rd),        64'(0));
    check("t4_x0_wd", 64'(wd),        64'(32'hFFFF));
    @(negedge clk);
    check("t4_last_rw", 64'(reg_write), 64'(1));
    check("t4_last_rd", 64'(rd),        64'(12));
    check("t4_last_wd", 64'(wd),        64'(32'hCC));
    @(negedge clk);

    // Scoreboard set/clear and set-wins
    issue_mark = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    issue_mark = 1'b0;
    check("t5_busy_set", 64'(busy), 64'(32'h80));
    mem_valid = 1'b1; mem_rd = 5'd7; mem_wd = 32'h77;
    @(negedge clk);
    mem_valid = 1'b0;
    check("t5_busy_queued", 64'(busy), 64'(32'h80));
    issue_mark = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    issue_mark = 1'b0;
    check("t5_busy_set_wins", 64'(busy),      64'(32'h80));
    check("t5_retire_rw",     64'(reg_write), 64'(1));
    check("t5_retire_wd",     64'(wd),        64'(32'h77));
    mem_valid = 1'b1; mem_rd = 5'd7; mem_wd = 32'h78;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_cleared", 64'(busy), 64'(0));
    issue_mark = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    issue_mark = 1'b0;
    check("t5_busy_x0", 64'(busy), 64'(0));
    issue_mark = 1'b1; issue_rd = 5'd4;
    @(negedge clk);
    issue_mark = 1'b0;
    check("t5_busy_r4", 64'(busy), 64'(32'h10));
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
    @(negedge clk);
    alu_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_alu_clear", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);

    // Reset with three entries queued
    mem_valid = 1'b1; mem_rd = 5'd20; mem_wd = 32'h20;
    alu_valid = 1'b1; alu_rd = 5'd21; alu_wd = 32'h21;
    issue_mark = 1'b1; issue_rd = 5'd22;
    @(negedge clk);
    mem_rd = 5'd22; mem_wd = 32'h22b; alu_rd = 5'd23; alu_wd = 32'h23;
    issue_mark = 1'b0;
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    check("t6_pre_rst_wd", 64'(wd), 64'(32'h20));
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_rw",        64'(reg_write), 64'(0));
    check("t6_rst_busy",      64'(busy),      64'(0));
    check("t6_rst_rd",        64'(rd),        64'(0));
    check("t6_rst_mem_ready", 64'(mem_ready), 64'(0));
    check("t6_rst_alu_ready", 64'(alu_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("t6_mem_ready", 64'(mem_ready), 64'(1));
    check("t6_alu_ready", 64'(alu_ready), 64'(1));
    wr_cnt = int'(reg_write);
    repeat (8) begin
      @(negedge clk);
      wr_cnt += int'(reg_write);
    end
    check("t6_no_retire", 64'(wr_cnt), 64'(0));
    check("t6_busy_after", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
